cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units (ALU, load/store buffer, branch unit, …) of the out-of-order core. Each cycle it grants at most one pending result, registers it, and broadcasts `{tag, value}` to the reorder buffer and reservation stations. Those units forward committed results into `reg_file`'s commit port. Tag 0 means "no producer" throughout the core, so it is never broadcast.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting units, 2..8.
- `DATA_W`, 32: result width; matches `REG_TYPE`.
- `TAG_W`, 4: ROB-entry id width; matches `RO_BUFFER_ID_TYPE`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  **asynchronous, active-low** reset.
- `rdy`  in  1  global run enable; low freezes all state.
- `reset_from_rob_bus`  in  1  mispredict flush, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-unit result pending.
- `req_tag`  in  NUM_REQ×TAG_W  per-unit ROB tag, packed, unit i at `[i*TAG_W +: TAG_W]`.
- `req_value`  in  NUM_REQ×DATA_W  per-unit result, packed the same way.
- `req_ready`  out  NUM_REQ  one-hot grant; the result transfers when `req_valid[i] && req_ready[i]`.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_value`  out  DATA_W  broadcast value.
- `cdb_src`  out  clog2(NUM_REQ)  index of the unit that produced the current broadcast.
- `tag0_err`  out  1  sticky flag: a tag-0 request was accepted.
- `busy_cnt`  out  32  saturating count of cycles with `cdb_valid`=1.

## Operation
- State:
  - `ptr`: highest-priority index.
  - Output registers `cdb_*`.
  - `tag0_err`.
  - `busy_cnt`.
- Grant, combinational:
  - The winner is the first i with `req_valid[i]`=1, scanning `ptr, ptr+1, …` modulo NUM_REQ.
  - `req_ready` is one-hot on the winner; it is all-zero if none is valid, `rdy`=0, or `reset_from_rob_bus`=1.
  - `req_ready` never depends on `req_tag` or `req_value`.
- Accept (edge with a grant):
  - `cdb_valid`←1, `cdb_tag`/`cdb_value`/`cdb_src`←winner's values.
  - `ptr`←(winner+1) mod NUM_REQ.
- Tag-0 request: it is accepted and consumed (`req_ready`=1, `ptr` advances), but `cdb_valid`←0 and `tag0_err`←1, sticky until reset.
- No grant and `rdy`=1: `cdb_valid`←0. `cdb_tag`/`cdb_value`/`cdb_src` hold their previous values.
- Flush (`reset_from_rob_bus`=1 with `rdy`=1):
  - No accept; `cdb_valid`←0; `ptr`←0.
  - `busy_cnt` and `tag0_err` are unchanged.
  - Flush takes precedence over any pending request.
- `rdy`=0: every register holds, including `cdb_valid`; the flush input is ignored.
- `busy_cnt`: increments on each `rdy`=1 edge where `cdb_valid`=1 before the edge. It saturates at 2^32−1.
- Requester contract: once `req_valid` is raised, tag and value stay stable until accepted. Flush is the only legal way to withdraw a request.

## Timing
- Reset (`rst`=0, asynchronous): `cdb_valid`=0, `cdb_tag`=0, `cdb_value`=0, `cdb_src`=0, `ptr`=0, `tag0_err`=0, `busy_cnt`=0. `req_ready`=0 while reset is asserted.
- Latency: request accepted at edge N → `cdb_*` valid during cycle N+1, for exactly one cycle unless a new grant follows.
- Throughput: one broadcast per cycle with back-to-back grants; there are no bubbles between different winners.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of `rdy`=1 operation without flush.
- A request valid in the same cycle as a flush is not accepted. It may be re-presented after the flush.
- Reset deassertion mid-stream: the first edge after `rst` rises may grant.

## Structure
- The shared config header defines `CDB_NUM_REQ` and the unit indices: ALU=0, LSB=1, BRU=2, MUL=3. Widths come from the existing `REG_TYPE` and `RO_BUFFER_ID_TYPE` macros.
- One sub-module, `cdb_rr_pick`: a combinational rotated priority encoder.
  - Inputs: `valid`, `ptr`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - It is reusable for a future second CDB.
- Total RTL ≈150–250 lines.

## Test plan
- Reset, then unit 1 alone: `req_valid`=0010, tag 5, value 0xDEADBEEF → `req_ready`=0010 in the same cycle; next cycle `cdb_valid`=1, tag 5, value 0xDEADBEEF, `cdb_src`=1; `ptr`=2.
- All four units valid continuously from `ptr`=0, with tags 1–4 and each unit presenting a fresh request every cycle → grant order 0,1,2,3,0; `cdb_valid` high for 5 consecutive cycles; `busy_cnt`=5.
- Units 0 and 2 valid, then flush asserted at cycle 1 → `req_ready`=0 in cycle 1; `cdb_valid`=0 in cycle 2; `ptr`=0; unit 0 is granted again afterwards.
- Unit 3 requests with `rdy` pulled low for 3 cycles → no grant; `cdb_valid` held at its prior value; grant occurs on the first cycle with `rdy`=1.
- Unit 0 presents tag 0 → `req_ready[0]`=1; `cdb_valid` stays 0 next cycle; `tag0_err`=1 until `rst` is asserted.
- Assert `rst` asynchronously mid-broadcast (between edges) → all outputs read 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared configuration for the common data bus: unit indices, default widths
// and the reserved "no producer" tag.
package cdb_arbiter_pkg;

   localparam int CDB_NUM_REQ = 4;
   localparam int REG_W       = 32;
   localparam int ROB_ID_W    = 4;

   typedef enum logic [2:0] {
      UNIT_ALU = 3'd0,
      UNIT_LSB = 3'd1,
      UNIT_BRU = 3'd2,
      UNIT_MUL = 3'd3
   } cdb_unit_e;

   localparam logic [ROB_ID_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/cdb_rr_pick.sv
// Rotated priority encoder: first valid index at or after ptr, wrapping modulo N.
// Purely combinational so a second bus can reuse it.
module cdb_rr_pick #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      // k is the distance from ptr; the smallest distance with a valid requester wins
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && valid[i] && (((int'(ptr) + k) % N) == i)) begin
               grant[i]  = 1'b1;
               grant_idx = IDX_W'(i);
               any       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one pending result per
// cycle and broadcasts its {tag, value} one cycle later.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = CDB_NUM_REQ,
   parameter  int DATA_W  = REG_W,
   parameter  int TAG_W   = ROB_ID_W,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      reset_from_rob_bus,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_W-1:0] req_value,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_value,
   output logic [IDX_W-1:0]          cdb_src,
   output logic                      tag0_err,
   output logic [31:0]               busy_cnt
);

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptr_next;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               grant_en;
   logic               accept;
   logic [TAG_W-1:0]   win_tag;
   logic [DATA_W-1:0]  win_value;
   logic               win_no_producer;

   cdb_rr_pick #(.N(NUM_REQ)) u_pick (
      .valid     (req_valid),
      .ptr       (ptr),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   // Grant is blocked while in reset, frozen, or flushing; tag/value never feed it.
   assign grant_en  = rst && rdy && !reset_from_rob_bus;
   assign accept    = grant_en && pick_any;
   assign req_ready = grant_en ? pick_grant : '0;

   always_comb begin
      win_tag   = '0;
      win_value = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) begin
            win_tag   = req_tag[i*TAG_W +: TAG_W];
            win_value = req_value[i*DATA_W +: DATA_W];
         end
      end
   end

   assign win_no_producer = (win_tag == TAG_W'(TAG_NONE));

   always_comb begin
      ptr_next = '0;
      if (int'(pick_idx) != NUM_REQ - 1) begin
         ptr_next = pick_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
         tag0_err  <= 1'b0;
         busy_cnt  <= '0;
      end else if (rdy) begin
         if (cdb_valid && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 32'd1;
         end
         if (reset_from_rob_bus) begin
            cdb_valid <= 1'b0;
            ptr       <= '0;
         end else if (accept) begin
            ptr <= ptr_next;
            // A tag-0 result is consumed so the unit drains, but never broadcast.
            if (win_no_producer) begin
               cdb_valid <= 1'b0;
               tag0_err  <= 1'b1;
            end else begin
               cdb_valid <= 1'b1;
               cdb_tag   <= win_tag;
               cdb_value <= win_value;
               cdb_src   <= pick_idx;
            end
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a
// queue, a negedge monitor pops and compares each new broadcast.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            rdy;
   logic            reset_from_rob_bus;
   logic [N-1:0]    req_valid;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_value;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic [1:0]      cdb_src;
   logic            tag0_err;
   logic [31:0]     busy_cnt;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] value;
      logic [1:0]    src;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic          rdy_q;
   logic [DW-1:0] val_model [N];

   cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .reset_from_rob_bus (reset_from_rob_bus),
      .req_valid          (req_valid),
      .req_tag            (req_tag),
      .req_value          (req_value),
      .req_ready          (req_ready),
      .cdb_valid          (cdb_valid),
      .cdb_tag            (cdb_tag),
      .cdb_value          (cdb_value),
      .cdb_src            (cdb_src),
      .tag0_err           (tag0_err),
      .busy_cnt           (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_unit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
      req_tag[i*TW +: TW]   = t;
      req_value[i*DW +: DW] = v;
   endtask

   task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] v, input logic [1:0] s);
      exp_t e;
      e.tag   = t;
      e.value = v;
      e.src   = s;
      sb.push_back(e);
   endtask

   task automatic do_reset;
      rst                = 1'b0;
      rdy                = 1'b1;
      reset_from_rob_bus = 1'b0;
      req_valid          = '0;
      #2;
      rst = 1'b1;
      tick();
   endtask

   // A broadcast is new only if the preceding edge was a running edge.
   always @(posedge clk) rdy_q <= rdy;

   always @(negedge clk) begin
      if (rst && cdb_valid && rdy_q) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_bcast: got tag 0x%0h src %0d, expected no broadcast",
                     cdb_tag, cdb_src);
         end else begin
            mon_e = sb.pop_front();
            chk("bcast_tag",   64'(cdb_tag),   64'(mon_e.tag));
            chk("bcast_value", 64'(cdb_value), 64'(mon_e.value));
            chk("bcast_src",   64'(cdb_src),   64'(mon_e.src));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b0;
      rdy                = 1'b1;
      reset_from_rob_bus = 1'b0;
      req_valid          = '1;
      req_tag            = '0;
      req_value          = '0;
      #2;
      chk("rst_ready",     64'(req_ready), 64'(0));
      chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("rst_cdb_tag",   64'(cdb_tag),   64'(0));
      chk("rst_cdb_value", 64'(cdb_value), 64'(0));
      chk("rst_cdb_src",   64'(cdb_src),   64'(0));
      chk("rst_tag0_err",  64'(tag0_err),  64'(0));
      chk("rst_busy_cnt",  64'(busy_cnt),  64'(0));
      req_valid = '0;
      #2;
      rst = 1'b1;
      tick();

      // Single requester on the load/store unit
      set_unit(int'(UNIT_LSB), 4'd5, 32'hDEAD_BEEF);
      req_valid = 4'b0010;
      #1;
      chk("t1_ready", 64'(req_ready), 64'(4'b0010));
      push(4'd5, 32'hDEAD_BEEF, 2'd1);
      tick();
      req_valid = '0;
      chk("t1_ptr", 64'(dut.ptr), 64'(2));
      tick();

      // All four units continuously valid: order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < N; i++) begin
         val_model[i] = 32'hC0DE_0000 + 32'(i);
         set_unit(i, 4'(i + 1), val_model[i]);
      end
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t2_ready", 64'(req_ready), 64'(4'b0001 << (c % N)));
         push(4'((c % N) + 1), val_model[c % N], 2'(c % N));
         tick();
         val_model[c % N] = 32'hF00D_0000 + 32'(c);
         set_unit(c % N, 4'((c % N) + 1), val_model[c % N]);
      end
      req_valid = '0;
      tick();
      chk("t2_busy_cnt",  64'(busy_cnt),  64'(5));
      chk("t2_cdb_valid", 64'(cdb_valid), 64'(0));

      // Flush wins over pending requests and resets the pointer
      do_reset();
      set_unit(0, 4'd7, 32'h7777_0000);
      set_unit(2, 4'd9, 32'h9999_0000);
      req_valid = 4'b0101;
      #1;
      chk("t3_ready_c0", 64'(req_ready), 64'(4'b0001));
      push(4'd7, 32'h7777_0000, 2'd0);
      tick();
      set_unit(0, 4'd7, 32'h7777_0001);
      reset_from_rob_bus = 1'b1;
      #1;
      chk("t3_ready_flush", 64'(req_ready), 64'(4'b0000));
      tick();
      reset_from_rob_bus = 1'b0;
      #1;
      chk("t3_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("t3_ptr",       64'(dut.ptr),   64'(0));
      chk("t3_ready_c2",  64'(req_ready), 64'(4'b0001));
      push(4'd7, 32'h7777_0001, 2'd0);
      tick();
      req_valid = 4'b0100;
      #1;
      chk("t3_ready_c3", 64'(req_ready), 64'(4'b0100));
      push(4'd9, 32'h9999_0000, 2'd2);
      tick();
      req_valid = '0;
      tick();

      // rdy low for three cycles freezes everything
      do_reset();
      set_unit(1, 4'd3, 32'h3333_3333);
      req_valid = 4'b0010;
      #1;
      push(4'd3, 32'h3333_3333, 2'd1);
      tick();
      set_unit(3, 4'd6, 32'h6666_6666);
      req_valid = 4'b1000;
      rdy       = 1'b0;
      #1;
      chk("t4_ready_frozen", 64'(req_ready), 64'(0));
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("t4_hold_valid", 64'(cdb_valid), 64'(1));
         chk("t4_hold_tag",   64'(cdb_tag),   64'(3));
         chk("t4_hold_ready", 64'(req_ready), 64'(0));
      end
      rdy = 1'b1;
      #1;
      chk("t4_ready_resume", 64'(req_ready), 64'(4'b1000));
      push(4'd6, 32'h6666_6666, 2'd3);
      tick();
      req_valid = '0;
      tick();
      chk("t4_busy_cnt", 64'(busy_cnt), 64'(2));

      // Tag 0 is consumed but not broadcast; error flag is sticky
      do_reset();
      set_unit(0, 4'd0, 32'h0000_1234);
      req_valid = 4'b0001;
      #1;
      chk("t5_ready_tag0", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      chk("t5_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("t5_tag0_err",  64'(tag0_err),  64'(1));
      chk("t5_ptr",       64'(dut.ptr),   64'(1));
      tick();
      tick();
      chk("t5_tag0_sticky", 64'(tag0_err), 64'(1));
      set_unit(0, 4'd2, 32'h0000_2222);
      req_valid = 4'b0001;
      #1;
      chk("t5_ready_wrap", 64'(req_ready), 64'(4'b0001));
      push(4'd2, 32'h0000_2222, 2'd0);
      tick();
      req_valid = '0;
      chk("t5_tag0_still", 64'(tag0_err), 64'(1));
      chk("t5_ptr_wrap",   64'(dut.ptr),  64'(1));

      // Asynchronous reset in the middle of a broadcast
      set_unit(2, 4'hA, 32'h0000_0055);
      req_valid = 4'b0100;
      #1;
      tick();
      chk("t6_pre_valid", 64'(cdb_valid), 64'(1));
      chk("t6_pre_tag",   64'(cdb_tag),   64'(4'hA));
      #2;
      rst = 1'b0;
      #1;
      chk("t6_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("t6_cdb_tag",   64'(cdb_tag),   64'(0));
      chk("t6_cdb_value", 64'(cdb_value), 64'(0));
      chk("t6_cdb_src",   64'(cdb_src),   64'(0));
      chk("t6_tag0_err",  64'(tag0_err),  64'(0));
      chk("t6_busy_cnt",  64'(busy_cnt),  64'(0));
      chk("t6_ready",     64'(req_ready), 64'(0));
      rst = 1'b1;
      #1;
      chk("t6_ready_after", 64'(req_ready), 64'(4'b0100));
      push(4'hA, 32'h0000_0055, 2'd2);
      tick();
      req_valid = '0;
      tick();
      tick();

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
